// File: rtl/pixie_fb_arbiter.sv
// Frame-buffer RAM arbiter: display reads > CPU request/ack accesses > screen-clear writes.
// One RAM access per cycle; the RAM port is a combinational mux of the slot winner.
module pixie_fb_arbiter #(
  parameter int unsigned          ADDR_W    = 10,
  parameter int unsigned          DATA_W    = 8,
  parameter logic [DATA_W-1:0]    CLR_VALUE = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_rd_en,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, CAPT, ACK} state_t;

  state_t            state;
  logic              cap_rd;
  logic              cpu_issue;
  logic              clr_wr;
  logic [ADDR_W:0]   clr_cnt;
  logic [ADDR_W:0]   clr_cnt_nxt;
  logic              disp_pend;
  logic [DATA_W-1:0] disp_hold;

  // Slot winners for this cycle; reset silences the RAM port entirely.
  assign cpu_issue = !reset && !disp_rd_en &&
                     ((state == IDLE && cpu_req) || state == WAIT);
  assign clr_wr    = !reset && clr_busy && !disp_rd_en && !cpu_issue;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (!reset) begin
      if (disp_rd_en) begin
        ram_en   = 1'b1;
        ram_addr = disp_addr;
      end else if (cpu_issue) begin
        ram_en    = 1'b1;
        ram_we    = cpu_we;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
      end else if (clr_wr) begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = clr_cnt[ADDR_W-1:0];
        ram_wdata = CLR_VALUE;
      end
    end
  end

  // Display sees RAM data the cycle after its read, then the held copy.
  assign disp_data = disp_pend ? ram_rdata : disp_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_pend <= 1'b0;
      disp_hold <= '0;
    end else begin
      disp_pend <= disp_rd_en;
      if (disp_pend) disp_hold <= ram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cap_rd    <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      cpu_ack <= 1'b0;
      case (state)
        IDLE: if (cpu_req) begin
          if (!disp_rd_en) begin
            state  <= CAPT;
            cap_rd <= !cpu_we;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: if (!disp_rd_en) begin
          state  <= CAPT;
          cap_rd <= !cpu_we;
        end
        CAPT: begin
          if (cap_rd) cpu_rdata <= ram_rdata;
          cpu_ack <= 1'b1;
          state   <= ACK;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The extra counter bit carries out on the write to the last location.
  assign clr_cnt_nxt = clr_cnt + {{ADDR_W{1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_busy <= 1'b0;
      clr_cnt  <= '0;
    end else if (clr_start && !clr_busy) begin
      clr_busy <= 1'b1;
      clr_cnt  <= '0;
    end else if (clr_wr) begin
      clr_cnt  <= clr_cnt_nxt;
      clr_busy <= !clr_cnt_nxt[ADDR_W];
    end
  end

endmodule
